// File: rtl/clint_timer.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp machine timer and msip software
// interrupt bit, serving one MEM-stage load/store at a time with a one-cycle response.
module clint_timer #(
   parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clint_req_valid_i,
   output logic        clint_req_ready_o,
   input  logic        clint_req_write_i,
   input  logic [63:0] clint_req_addr_i,
   input  logic [63:0] clint_req_wdata_i,
   input  logic [7:0]  clint_req_wstrb_i,
   output logic        clint_resp_valid_o,
   output logic [63:0] clint_resp_rdata_o,
   output logic        clint_resp_err_o,
   output logic        clint_mtip_o,
   output logic        clint_update_o,
   output logic        clint_msip_o
);

   localparam logic [63:0] OffMsip   = 64'h0000;
   localparam logic [63:0] OffMsipHi = 64'h0004;
   localparam logic [63:0] OffCmp    = 64'h4000;
   localparam logic [63:0] OffMtime  = 64'hBFF8;
   localparam logic [15:0] DivLast   = 16'(TICK_DIV - 1);

   typedef enum logic {StIdle, StResp} state_e;

   state_e      state_q, state_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [63:0] rdata_q, rdata_d;
   logic [15:0] div_q, div_d;
   logic        msip_q, msip_d;
   logic        err_q, err_d;
   logic        mtip_q, mtip_d;
   logic        update_q, update_d;

   logic [63:0] offset;
   logic [63:0] wmask;
   logic [63:0] rd_val;
   logic        hit_msip, hit_msip_hi, hit_cmp, hit_mtime, hit_any;

   // Only exact register offsets hit, so any misaligned address falls through to an error.
   assign offset      = clint_req_addr_i - BASE_ADDR;
   assign hit_msip    = (offset == OffMsip);
   assign hit_msip_hi = (offset == OffMsipHi);
   assign hit_cmp     = (offset == OffCmp);
   assign hit_mtime   = (offset == OffMtime);
   assign hit_any     = hit_msip | hit_msip_hi | hit_cmp | hit_mtime;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         wmask[8*i +: 8] = {8{clint_req_wstrb_i[i]}};
      end
   end

   always_comb begin
      rd_val = '0;
      if (hit_msip) begin
         rd_val = {63'b0, msip_q};
      end else if (hit_cmp) begin
         rd_val = mtimecmp_q;
      end else if (hit_mtime) begin
         rd_val = mtime_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      msip_d     = msip_q;
      mtimecmp_d = mtimecmp_q;
      if (div_q == DivLast) begin
         div_d   = '0;
         mtime_d = mtime_q + 64'd1;
      end else begin
         div_d   = div_q + 16'd1;
         mtime_d = mtime_q;
      end

      case (state_q)
         StIdle: begin
            if (clint_req_valid_i) begin
               state_d = StResp;
               err_d   = ~hit_any;
               rdata_d = (clint_req_write_i || !hit_any) ? 64'd0 : rd_val;
               if (clint_req_write_i) begin
                  if (hit_msip && clint_req_wstrb_i[0]) begin
                     msip_d = clint_req_wdata_i[0];
                  end
                  if (hit_cmp) begin
                     mtimecmp_d = (mtimecmp_q & ~wmask) | (clint_req_wdata_i & wmask);
                  end
                  // A real mtime store overrides the tick and restarts the divider phase.
                  if (hit_mtime && (clint_req_wstrb_i != 8'd0)) begin
                     mtime_d = (mtime_q & ~wmask) | (clint_req_wdata_i & wmask);
                     div_d   = '0;
                  end
               end
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      mtip_d   = (mtime_q >= mtimecmp_q);
      update_d = mtip_d ^ mtip_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         rdata_q    <= '0;
         div_q      <= '0;
         msip_q     <= 1'b0;
         err_q      <= 1'b0;
         mtip_q     <= 1'b0;
         update_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         rdata_q    <= rdata_d;
         div_q      <= div_d;
         msip_q     <= msip_d;
         err_q      <= err_d;
         mtip_q     <= mtip_d;
         update_q   <= update_d;
      end
   end

   assign clint_req_ready_o  = (state_q == StIdle);
   assign clint_resp_valid_o = (state_q == StResp);
   assign clint_resp_rdata_o = rdata_q;
   assign clint_resp_err_o   = err_q;
   assign clint_mtip_o       = mtip_q;
   assign clint_update_o     = update_q;
   assign clint_msip_o       = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) checked against a time-formula model
// where mtime = last written value + elapsed clock edges / TICK_DIV.
module tb_clint_timer;
   localparam logic [63:0] Base     = 64'h0200_0000;
   localparam logic [63:0] OffMsip  = 64'h0000;
   localparam logic [63:0] OffMsipH = 64'h0004;
   localparam logic [63:0] OffCmp   = 64'h4000;
   localparam logic [63:0] OffMt    = 64'hBFF8;
   localparam logic [63:0] Ones     = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk, rst;
   logic        req_valid [2];
   logic        req_write [2];
   logic [63:0] req_addr  [2];
   logic [63:0] req_wdata [2];
   logic [7:0]  req_wstrb [2];
   logic        req_ready [2];
   logic        resp_valid [2];
   logic [63:0] resp_rdata [2];
   logic        resp_err  [2];
   logic        mtip      [2];
   logic        upd       [2];
   logic        msip      [2];

   int          checks, errors;
   int          upd_cnt [2] = '{0, 0};
   logic [63:0] ecnt;
   logic [63:0] base_m  [2];
   logic [63:0] bedge_m [2];
   logic [63:0] cmp_m   [2];
   logic        msip_m  [2];
   logic        exp_mtip [2];
   logic        exp_upd  [2];
   logic [63:0] rd;

   clint_timer #(.BASE_ADDR(Base), .TICK_DIV(1)) dut (
      .clk(clk), .rst(rst),
      .clint_req_valid_i(req_valid[0]), .clint_req_ready_o(req_ready[0]),
      .clint_req_write_i(req_write[0]), .clint_req_addr_i(req_addr[0]),
      .clint_req_wdata_i(req_wdata[0]), .clint_req_wstrb_i(req_wstrb[0]),
      .clint_resp_valid_o(resp_valid[0]), .clint_resp_rdata_o(resp_rdata[0]),
      .clint_resp_err_o(resp_err[0]), .clint_mtip_o(mtip[0]),
      .clint_update_o(upd[0]), .clint_msip_o(msip[0])
   );

   clint_timer #(.BASE_ADDR(Base), .TICK_DIV(4)) dut4 (
      .clk(clk), .rst(rst),
      .clint_req_valid_i(req_valid[1]), .clint_req_ready_o(req_ready[1]),
      .clint_req_write_i(req_write[1]), .clint_req_addr_i(req_addr[1]),
      .clint_req_wdata_i(req_wdata[1]), .clint_req_wstrb_i(req_wstrb[1]),
      .clint_resp_valid_o(resp_valid[1]), .clint_resp_rdata_o(resp_rdata[1]),
      .clint_resp_err_o(resp_err[1]), .clint_mtip_o(mtip[1]),
      .clint_update_o(upd[1]), .clint_msip_o(msip[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Clock edges seen since reset release.
   always @(posedge clk or negedge rst) begin
      if (!rst) ecnt <= '0;
      else      ecnt <= ecnt + 64'd1;
   end

   function automatic logic [63:0] mt(input int d, input logic [63:0] e);
      return base_m[d] + (e - bedge_m[d]) / ((d == 1) ? 64'd4 : 64'd1);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] st);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Expected interrupt level: registered comparison of the previous cycle's model values.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_mtip <= '{1'b0, 1'b0};
         exp_upd  <= '{1'b0, 1'b0};
      end else begin
         for (int i = 0; i < 2; i++) begin
            exp_mtip[i] <= (mt(i, ecnt) >= cmp_m[i]);
            exp_upd[i]  <= (mt(i, ecnt) >= cmp_m[i]) ^ exp_mtip[i];
         end
      end
   end

   always @(negedge clk) begin
      if (upd[0] === 1'b1) upd_cnt[0] <= upd_cnt[0] + 1;
      if (upd[1] === 1'b1) upd_cnt[1] <= upd_cnt[1] + 1;
   end

   task automatic reset_model();
      for (int d = 0; d < 2; d++) begin
         base_m[d]  = '0;
         bedge_m[d] = '0;
         cmp_m[d]   = Ones;
         msip_m[d]  = 1'b0;
      end
   endtask

   task automatic bus(input int d, input bit wr, input logic [63:0] off, input logic [63:0] wd,
                      input logic [7:0] st, output logic [63:0] rdo);
      logic [63:0] mt_old, exp_rd;
      logic        is_msip, is_hi, is_cmp, is_mt, exp_err;
      @(negedge clk);
      is_msip = (off == OffMsip);
      is_hi   = (off == OffMsipH);
      is_cmp  = (off == OffCmp);
      is_mt   = (off == OffMt);
      exp_err = !(is_msip || is_hi || is_cmp || is_mt);
      mt_old  = mt(d, ecnt);
      exp_rd  = is_msip ? {63'b0, msip_m[d]} : is_cmp ? cmp_m[d] : is_mt ? mt_old : 64'd0;
      checks++;
      if (req_ready[d] !== 1'b1) begin
         errors++; $display("FAIL ready_idle d%0d: got %b want 1", d, req_ready[d]);
      end
      req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = Base + off;
      req_wdata[d] = wd;   req_wstrb[d] = st;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      if (wr) begin
         if (is_msip && st[0]) msip_m[d] = wd[0];
         if (is_cmp) cmp_m[d] = merge(cmp_m[d], wd, st);
         if (is_mt && st != 8'd0) begin
            base_m[d]  = merge(mt_old, wd, st);
            bedge_m[d] = ecnt;
         end
      end
      rdo = resp_rdata[d];
      checks++;
      if (resp_valid[d] !== 1'b1) begin
         errors++; $display("FAIL resp_valid d%0d off %h: got %b want 1", d, off, resp_valid[d]);
      end
      checks++;
      if (req_ready[d] !== 1'b0) begin
         errors++; $display("FAIL ready_busy d%0d: got %b want 0", d, req_ready[d]);
      end
      checks++;
      if (resp_err[d] !== exp_err) begin
         errors++; $display("FAIL resp_err d%0d off %h: got %b want %b", d, off, resp_err[d], exp_err);
      end
      if (!wr) begin
         checks++;
         if (resp_rdata[d] !== exp_rd) begin
            errors++;
            $display("FAIL rdata d%0d off %h: got %h want %h", d, off, resp_rdata[d], exp_rd);
         end
      end
      checks++;
      if (mtip[d] !== exp_mtip[d] || upd[d] !== exp_upd[d]) begin
         errors++; $display("FAIL mtip_upd_resp d%0d: got %b%b want %b%b", d, mtip[d], upd[d],
                            exp_mtip[d], exp_upd[d]);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
         errors++; $display("FAIL resp_one_cycle d%0d: got valid %b ready %b want 0 1", d,
                            resp_valid[d], req_ready[d]);
      end
      checks++;
      if (mtip[d] !== exp_mtip[d] || upd[d] !== exp_upd[d] || msip[d] !== msip_m[d]) begin
         errors++; $display("FAIL mtip_upd_msip d%0d: got %b%b%b want %b%b%b", d, mtip[d], upd[d],
                            msip[d], exp_mtip[d], exp_upd[d], msip_m[d]);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_err[d] !== 1'b0) begin
            errors++; $display("FAIL reset_hs d%0d: got ready %b valid %b err %b want 1 0 0", d,
                               req_ready[d], resp_valid[d], resp_err[d]);
         end
         checks++;
         if (mtip[d] !== 1'b0 || upd[d] !== 1'b0 || msip[d] !== 1'b0) begin
            errors++; $display("FAIL reset_irq d%0d: got %b%b%b want 000", d, mtip[d], upd[d],
                               msip[d]);
         end
         checks++;
         if (resp_rdata[d] !== 64'd0) begin
            errors++; $display("FAIL reset_rdata d%0d: got %h want 0", d, resp_rdata[d]);
         end
      end
   endtask

   task automatic test_read_mtime();
      for (int i = 0; i < 20 && ecnt < 64'd8; i++) @(negedge clk);
      bus(0, 1'b0, OffMt, 64'd0, 8'd0, rd);
      checks++;
      if (rd !== 64'd9) begin
         errors++; $display("FAIL mtime_cycle10: got %h want 9", rd);
      end
      bus(0, 1'b0, OffCmp, 64'd0, 8'd0, rd);
   endtask

   task automatic test_mtip_rise();
      int c0;
      logic seen;
      bus(0, 1'b1, OffMt, 64'h10, 8'hFF, rd);
      bus(0, 1'b1, OffCmp, 64'h20, 8'hFF, rd);
      c0 = upd_cnt[0];
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         checks++;
         if (mtip[0] !== exp_mtip[0] || upd[0] !== exp_upd[0]) begin
            errors++; $display("FAIL rise_track: got %b%b want %b%b", mtip[0], upd[0],
                               exp_mtip[0], exp_upd[0]);
         end
         if (!seen && mtip[0] === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (mt(0, ecnt - 64'd1) !== 64'h20) begin
               errors++; $display("FAIL rise_time: mtime was %h want 20", mt(0, ecnt - 64'd1));
            end
         end
      end
      @(negedge clk); #1;
      checks++;
      if (seen !== 1'b1 || upd_cnt[0] - c0 !== 1) begin
         errors++; $display("FAIL rise_pulses: got seen %b pulses %0d want 1 1", seen,
                            upd_cnt[0] - c0);
      end
   endtask

   task automatic test_cmp_clear();
      int c0;
      c0 = upd_cnt[0];
      bus(0, 1'b1, OffCmp, Ones, 8'hFF, rd);
      @(negedge clk); #1;
      checks++;
      if (mtip[0] !== 1'b0 || upd_cnt[0] - c0 !== 1) begin
         errors++; $display("FAIL cmp_clear: got mtip %b pulses %0d want 0 1", mtip[0],
                            upd_cnt[0] - c0);
      end
      bus(0, 1'b0, OffCmp, 64'd0, 8'd0, rd);
      checks++;
      if (rd !== Ones) begin
         errors++; $display("FAIL cmp_readback: got %h want all ones", rd);
      end
   endtask

   task automatic test_wrap();
      int c0;
      c0 = upd_cnt[0];
      bus(0, 1'b1, OffMt, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd);
      bus(0, 1'b0, OffMt, 64'd0, 8'd0, rd);
      checks++;
      if (rd !== Ones) begin
         errors++; $display("FAIL wrap_next: got %h want all ones", rd);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (mtip[0] !== exp_mtip[0]) begin
            errors++; $display("FAIL wrap_mtip: got %b want %b", mtip[0], exp_mtip[0]);
         end
      end
      @(negedge clk); #1;
      checks++;
      if (upd_cnt[0] - c0 !== 2 || mtip[0] !== 1'b0) begin
         errors++; $display("FAIL wrap_pulses: got %0d mtip %b want 2 0", upd_cnt[0] - c0, mtip[0]);
      end
      bus(0, 1'b0, OffMt, 64'd0, 8'd0, rd);
   endtask

   task automatic test_tickdiv4();
      // First store lands on a tick edge, second one between ticks.
      for (int i = 0; i < 4 && (ecnt % 4) != 64'd2; i++) @(negedge clk);
      bus(1, 1'b1, OffMt, 64'h100, 8'hFF, rd);
      bus(1, 1'b0, OffMt, 64'd0, 8'd0, rd);
      checks++;
      if (rd !== 64'h100) begin
         errors++; $display("FAIL div4_tick_write: got %h want 100", rd);
      end
      for (int i = 0; i < 4; i++) bus(1, 1'b0, OffMt, 64'd0, 8'd0, rd);
      for (int i = 0; i < 4 && (ecnt % 4) != 64'd0; i++) @(negedge clk);
      bus(1, 1'b1, OffMt, 64'h200, 8'hFF, rd);
      for (int i = 0; i < 5; i++) bus(1, 1'b0, OffMt, 64'd0, 8'd0, rd);
      checks++;
      if (rd !== 64'h202) begin
         errors++; $display("FAIL div4_restart: got %h want 202", rd);
      end
   endtask

   task automatic test_partial_and_errors();
      bus(0, 1'b1, OffCmp, 64'd0, 8'hFF, rd);
      bus(0, 1'b1, OffCmp, 64'h1234_5678, 8'h0F, rd);
      bus(0, 1'b1, OffCmp, Ones, 8'h00, rd);
      bus(0, 1'b0, OffCmp, 64'd0, 8'd0, rd);
      checks++;
      if (rd !== 64'h1234_5678) begin
         errors++; $display("FAIL partial_cmp: got %h want 12345678", rd);
      end
      bus(0, 1'b1, OffMsip, 64'hFFFF_FFFF, 8'h0F, rd);
      bus(0, 1'b0, OffMsip, 64'd0, 8'd0, rd);
      checks++;
      if (rd !== 64'd1 || msip[0] !== 1'b1) begin
         errors++; $display("FAIL msip_set: got rd %h msip %b want 1 1", rd, msip[0]);
      end
      bus(0, 1'b1, OffMsipH, Ones, 8'hFF, rd);
      bus(0, 1'b0, OffMsipH, 64'd0, 8'd0, rd);
      bus(0, 1'b0, 64'h0008, 64'd0, 8'd0, rd);
      bus(0, 1'b0, 64'hBFF9, 64'd0, 8'd0, rd);
      bus(0, 1'b1, 64'hBFF9, 64'd0, 8'hFF, rd);
      bus(0, 1'b1, 64'h4004, 64'd0, 8'hFF, rd);
      bus(0, 1'b0, OffMt, 64'd0, 8'd0, rd);
      bus(0, 1'b0, OffCmp, 64'd0, 8'd0, rd);
   endtask

   task automatic test_random();
      logic [63:0] offs [8];
      offs = '{OffMsip, OffMsipH, OffCmp, OffMt, OffCmp, 64'h0008, 64'h4002, 64'h0010_0000};
      for (int i = 0; i < 60; i++) begin
         bus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), offs[$urandom_range(0, 7)],
             {$urandom, $urandom}, 8'($urandom_range(0, 255)), rd);
      end
   endtask

   task automatic test_reset_mid();
      bus(0, 1'b1, OffMsip, 64'd1, 8'h01, rd);
      bus(0, 1'b1, OffCmp, 64'd0, 8'hFF, rd);
      @(negedge clk);
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = Base + OffMt;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      checks++;
      if (resp_valid[0] !== 1'b1 || mtip[0] !== 1'b1) begin
         errors++; $display("FAIL mid_setup: got valid %b mtip %b want 1 1", resp_valid[0], mtip[0]);
      end
      rst = 1'b0;
      reset_model();
      #1;
      checks++;
      if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
         errors++; $display("FAIL mid_reset_resp: got valid %b ready %b want 0 1", resp_valid[0],
                            req_ready[0]);
      end
      checks++;
      if (mtip[0] !== 1'b0 || msip[0] !== 1'b0 || resp_rdata[0] !== 64'd0) begin
         errors++; $display("FAIL mid_reset_state: got mtip %b msip %b rdata %h want 0 0 0",
                            mtip[0], msip[0], resp_rdata[0]);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      test_reset();
      bus(0, 1'b0, OffMt, 64'd0, 8'd0, rd);
      bus(0, 1'b0, OffCmp, 64'd0, 8'd0, rd);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
         req_wdata[d] = '0;   req_wstrb[d] = '0;
      end
      reset_model();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      test_reset();
      test_read_mtime();
      test_mtip_rise();
      test_cmp_clear();
      test_wrap();
      test_tickdiv4();
      test_partial_and_errors();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor: memory-mapped machine timer (mtime, mtimecmp) and software-interrupt bit (msip).
- Sits on the data-memory side of the pipeline and responds to load/store requests issued by the MEM stage.
- Drives the timer-pending level and update pulse consumed by the CSR unit's mip[7] logic.

Parameters:
- BASE_ADDR, 64'h0200_0000, CLINT base address; all offsets are relative to it.
- TICK_DIV, 1, clock cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- clint_req_valid_i  input  1  request valid
- clint_req_ready_o  output  1  ready to accept a request
- clint_req_write_i  input  1  1 = store, 0 = load
- clint_req_addr_i  input  64  byte address
- clint_req_wdata_i  input  64  store data
- clint_req_wstrb_i  input  8  byte strobes (store only)
- clint_resp_valid_o  output  1  one-cycle response pulse
- clint_resp_rdata_o  output  64  load data, valid with resp_valid
- clint_resp_err_o  output  1  unmapped or misaligned access, valid with resp_valid
- clint_mtip_o  output  1  timer interrupt pending level
- clint_update_o  output  1  one-cycle pulse when clint_mtip_o changes
- clint_msip_o  output  1  software interrupt pending (msip bit 0)

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x0000: msip, 32-bit; only bit 0 is writable, the rest read 0.
  - 0x4000: mtimecmp, 64-bit.
  - 0xBFF8: mtime, 64-bit.
- Reset values: mtime 0; mtimecmp 64'hFFFF_FFFF_FFFF_FFFF; msip 0; divider 0; FSM IDLE.
- Output reset values: req_ready 1; resp_valid 0; resp_rdata 0; resp_err 0; mtip 0; update 0; msip 0.
- Reset may assert mid-transaction: all state clears immediately and no response is issued.
- FSM:
  - States: IDLE, RESP.
  - req_ready_o = (state == IDLE).
  - IDLE, req_valid=1: capture the request, perform the write or latch the read data at this clock edge, go to RESP.
  - RESP: resp_valid_o = 1 for exactly one cycle, then return to IDLE.
  - Latency is 1 cycle from accept to response. Maximum throughput is one request per 2 cycles; one request outstanding at most.
- Address decode:
  - Addresses that are not 8-byte aligned, or hit no register, give resp_err = 1 and rdata = 0, with no state change.
  - An msip access requires a 4-byte-aligned address. Offset 0x0004 reads 0 and ignores writes, with no error.
- Writes: byte-merge using wstrb (byte i updates bits 8i+7:8i). wstrb = 0 is a legal no-op.
- Reads: return the register value before any same-edge update. mtime reads its current value, not the incremented one.
- mtime counting:
  - The divider counts 0..TICK_DIV-1; mtime increments by 1 when the divider equals TICK_DIV-1.
  - With TICK_DIV=1, mtime increments every cycle.
  - 64-bit unsigned wrap: FFFF_FFFF_FFFF_FFFF -> 0.
- mtime write vs. tick on the same edge: the write wins (merged value, no increment) and the divider resets to 0.
- Compare (unsigned), both outputs registered:
  - mtip_nxt = (mtime >= mtimecmp), computed from current register values.
  - update_nxt = mtip_nxt ^ clint_mtip_o.
  - A write to mtimecmp or mtime is reflected on mtip 1 cycle after the write edge.
  - clint_update_o is high in exactly the cycle clint_mtip_o takes its new value. It never asserts without a change.
- clint_msip_o = msip bit 0, registered.

Test Plan:
- After reset: mtip=0, update=0, req_ready=1. Load 0xBFF8 at cycle 10 (TICK_DIV=1) -> resp_valid exactly 1 cycle later, rdata = mtime value at the accept edge, err=0.
- Store mtimecmp=0x20 with wstrb=0xFF while mtime=0x10 -> mtip rises in the cycle mtime reaches 0x20 plus 1; update pulses high for exactly that cycle.
- With mtip=1, store mtimecmp=0xFFFF_FFFF_FFFF_FFFF -> mtip falls 1 cycle after the write edge, with a single update pulse; a later load of mtimecmp returns all ones.
- Store mtime=0xFFFF_FFFF_FFFF_FFFE -> mtime reads ...FFFF next, then 0 (wrap). With mtimecmp=0xFFFF_FFFF_FFFF_FFFF, mtip goes 1 then 0, with two update pulses.
- TICK_DIV=4: mtime advances once per 4 cycles. A store to mtime on a tick edge loads the written value without increment and restarts the divider.
- Partial store wstrb=0x0F, wdata=0x1234_5678 to mtimecmp=0 -> mtimecmp=0x0000_0000_1234_5678. Store msip=0xFFFF_FFFF -> msip_o=1, read returns 1. Load 0x0008 or misaligned 0xBFF9 -> err=1, rdata=0. Assert rst during RESP -> resp_valid drops immediately.
